// File: rtl/axi4_lite_slave_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi4_lite_pkg
// Description : Shared AXI4-Lite response codes and width-derivation helpers
//               for the register-bank slave and its address decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Byte-offset bits inside one data word.
  function automatic int addr_lsb(input int data_width);
    return clog2(data_width / 8);
  endfunction

  // Register index width, never narrower than one bit.
  function automatic int idx_width(input int num_regs);
    return (clog2(num_regs) < 1) ? 1 : clog2(num_regs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_slave_regbank_if.sv
`default_nettype none
// ============================================================================
// Interface   : axi4_lite_slave_regbank_if
// Description : AXI4-Lite AW/W/B/AR/R channel bundle with master and slave
//               views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_lite_slave_regbank_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_slave_regbank_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_addr_decode
// Description : Byte address -> register index, in-range and read-only flags.
//               Byte-offset bits are ignored so misaligned addresses hit the
//               containing word.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int                ADDR_WIDTH = 32,
  parameter int                DATA_WIDTH = 32,
  parameter int                NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  wire logic [ADDR_WIDTH-1:0]             i_addr,
  output logic      [idx_width(NUM_REGS)-1:0]    o_idx,
  output logic                                   o_in_range,
  output logic                                   o_is_ro
);
  localparam int c_ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int c_IDX_W    = idx_width(NUM_REGS);

  logic [ADDR_WIDTH-1:0] w_upper;
  logic                  w_unused_lsb;

  assign o_idx        = i_addr[c_ADDR_LSB +: c_IDX_W];
  assign w_upper      = i_addr >> (c_ADDR_LSB + c_IDX_W);
  assign w_unused_lsb = ^i_addr[c_ADDR_LSB-1:0];

  // Index must exist and every bit above the index field must be zero.
  always_comb begin
    o_in_range = (w_upper == '0) && (int'(o_idx) < NUM_REGS);
    o_is_ro    = o_in_range && RO_MASK[o_idx];
  end
endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_slave_regbank
// Description : AXI4-Lite slave register bank. Decoupled AW/W capture,
//               byte-strobe writes, read-only slots fed from user inputs,
//               SLVERR on out-of-range or read-only writes.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_regbank
  import axi4_lite_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  wire logic                           iCLK,
  input  wire logic                           iRST,
  axi4_lite_slave_regbank_if.slave            s,
  output logic [NUM_REGS*DATA_WIDTH-1:0]      oREGS,
  input  wire logic [NUM_REGS*DATA_WIDTH-1:0] iRO_DATA
);
  localparam int c_STRB_W = DATA_WIDTH / 8;
  localparam int c_IDX_W  = idx_width(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  r_aw_held;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [c_STRB_W-1:0]   r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic [c_IDX_W-1:0]    w_wr_idx;
  logic                  w_wr_in_range;
  logic                  w_wr_is_ro;
  logic                  w_wr_ok;
  logic [c_IDX_W-1:0]    w_rd_idx;
  logic                  w_rd_in_range;
  logic                  w_rd_is_ro;
  logic [DATA_WIDTH-1:0] w_rd_value;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic                  w_unused;

  axi4_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_wr_decode (
    .i_addr     (r_aw_addr),
    .o_idx      (w_wr_idx),
    .o_in_range (w_wr_in_range),
    .o_is_ro    (w_wr_is_ro)
  );

  axi4_lite_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_rd_decode (
    .i_addr     (s.araddr),
    .o_idx      (w_rd_idx),
    .o_in_range (w_rd_in_range),
    .o_is_ro    (w_rd_is_ro)
  );

  // Ready signals are forced low while reset is asserted.
  assign s.awready = !iRST && !r_aw_held;
  assign s.wready  = !iRST && !r_w_held;
  assign s.arready = !iRST && !r_rvalid;
  assign s.bvalid  = r_bvalid;
  assign s.bresp   = r_bresp;
  assign s.rvalid  = r_rvalid;
  assign s.rdata   = r_rdata;
  assign s.rresp   = r_rresp;

  assign w_aw_hs  = s.awvalid && s.awready;
  assign w_w_hs   = s.wvalid && s.wready;
  assign w_ar_hs  = s.arvalid && s.arready;
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;
  assign w_wr_ok  = w_wr_in_range && !w_wr_is_ro;
  assign w_unused = ^{s.awprot, s.arprot};

  // Capture AW and W independently; release both on commit and raise B.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s.awaddr;
      end else if (w_commit) begin
        r_aw_held <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s.wdata;
        r_w_strb <= s.wstrb;
      end else if (w_commit) begin
        r_w_held <= 1'b0;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && s.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Byte-lane update of the targeted writable register on commit.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && w_wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < c_STRB_W; b++) begin
          if (int'(w_wr_idx) == i && r_w_strb[b])
            r_regs[i][b*8 +: 8] <= r_w_data[b*8 +: 8];
        end
      end
    end
  end

  // Read source: RO slots come from user input, others from storage.
  always_comb begin
    w_rd_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(w_rd_idx) == i)
        w_rd_value = RO_MASK[i] ? iRO_DATA[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
    end
    if (!w_rd_in_range || (w_rd_is_ro && 1'b0))
      w_rd_value = '0;
  end

  // Single-entry read response; sampled storage predates a same-edge write.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_value;
      r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rvalid && s.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
      if (RO_MASK[gi]) begin : g_ro
        assign oREGS[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin : g_rw
        assign oREGS[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
      end
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_slave_regbank
// Description : Self-checking bench: cycle-level queue model of the register
//               bank, directed scenarios with literal expectations, then
//               randomized traffic on all channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_slave_regbank;
  logic         iCLK;
  logic         iRST;
  logic [255:0] oregs;
  logic [255:0] ro_data;

  int vectors;
  int miscompares;

  axi4_lite_slave_regbank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave_regbank #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (8),
    .RO_MASK    (8'h04)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .s        (bus),
    .oREGS    (oregs),
    .iRO_DATA (ro_data)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // ---------------- reference model ----------------
  logic [7:0]  ro_mask = 8'h04;
  logic [31:0] m_regs [8];
  logic [31:0] m_aw_q [$];
  logic [35:0] m_w_q  [$];
  logic        m_bvalid, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_aw_q.delete();
    m_w_q.delete();
    m_bvalid = 0; m_rvalid = 0;
    m_bresp = 0; m_rresp = 0; m_rdata = 0;
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < 8; i++)
      if (!ro_mask[i]) f[i*32 +: 32] = m_regs[i];
    return f;
  endfunction

  // Advance the model across the coming rising edge using current inputs.
  function automatic void model_step();
    bit aw_free, w_free, commit, rd;
    logic [31:0] a, word;
    logic [35:0] wd;
    aw_free = (m_aw_q.size() == 0);
    w_free  = (m_w_q.size() == 0);
    commit  = !aw_free && !w_free && !m_bvalid;
    rd      = bus.arvalid && !m_rvalid;
    if (m_rvalid && bus.rready) m_rvalid = 0;
    if (rd) begin
      word = bus.araddr >> 2;
      m_rvalid = 1;
      if (word < 8) begin
        m_rdata = ro_mask[word[2:0]] ? ro_data[int'(word)*32 +: 32] : m_regs[word[2:0]];
        m_rresp = 2'b00;
      end else begin
        m_rdata = 0;
        m_rresp = 2'b10;
      end
    end
    if (m_bvalid && bus.bready) m_bvalid = 0;
    if (commit) begin
      a = m_aw_q.pop_front();
      wd = m_w_q.pop_front();
      word = a >> 2;
      m_bvalid = 1;
      if (word < 8 && !ro_mask[word[2:0]]) begin
        m_bresp = 2'b00;
        for (int b = 0; b < 4; b++)
          if (wd[32+b]) m_regs[word[2:0]][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        m_bresp = 2'b10;
      end
    end
    if (bus.awvalid && aw_free) m_aw_q.push_back(bus.awaddr);
    if (bus.wvalid && w_free)   m_w_q.push_back({bus.wstrb, bus.wdata});
  endfunction

  // Compare DUT against the model every cycle, then advance the model.
  always @(negedge iCLK) begin
    if (iRST) model_reset();
    chk("awready", bus.awready, !iRST && m_aw_q.size() == 0);
    chk("wready",  bus.wready,  !iRST && m_w_q.size() == 0);
    chk("arready", bus.arready, !iRST && !m_rvalid);
    chk("bvalid",  bus.bvalid,  m_bvalid);
    chk("rvalid",  bus.rvalid,  m_rvalid);
    if (iRST) begin
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_bresp", bus.bresp, 0);
      chk("rst_rresp", bus.rresp, 0);
    end
    if (m_bvalid) chk("bresp", bus.bresp, m_bresp);
    if (m_rvalid) begin
      chk("rdata", bus.rdata, m_rdata);
      chk("rresp", bus.rresp, m_rresp);
    end
    chk("oregs", oregs, model_flat());
    if (!iRST) model_step();
  end

  // ---------------- drivers ----------------
  task automatic drive_aw(input logic [31:0] a);
    bit ok = 0;
    bus.awvalid = 1; bus.awaddr = a; bus.awprot = 3'($urandom);
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge iCLK);
      if (bus.awready) ok = 1;
    end
    if (!ok) timeout("aw_handshake");
    @(posedge iCLK); #1;
    bus.awvalid = 0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] st);
    bit ok = 0;
    bus.wvalid = 1; bus.wdata = d; bus.wstrb = st;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge iCLK);
      if (bus.wready) ok = 1;
    end
    if (!ok) timeout("w_handshake");
    @(posedge iCLK); #1;
    bus.wvalid = 0;
  endtask

  task automatic drive_ar(input logic [31:0] a);
    bit ok = 0;
    bus.arvalid = 1; bus.araddr = a; bus.arprot = 3'($urandom);
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge iCLK);
      if (bus.arready) ok = 1;
    end
    if (!ok) timeout("ar_handshake");
    @(posedge iCLK); #1;
    bus.arvalid = 0;
  endtask

  task automatic wait_b(output logic [1:0] resp);
    bit ok = 0;
    resp = 2'bxx;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge iCLK);
      if (bus.bvalid) begin ok = 1; resp = bus.bresp; end
    end
    if (!ok) timeout("b_wait");
    @(posedge iCLK); #1;
  endtask

  task automatic wait_r(output logic [31:0] data, output logic [1:0] resp);
    bit ok = 0;
    data = 'x; resp = 2'bxx;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge iCLK);
      if (bus.rvalid) begin ok = 1; data = bus.rdata; resp = bus.rresp; end
    end
    if (!ok) timeout("r_wait");
    @(posedge iCLK); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          output logic [1:0] resp);
    fork
      drive_aw(a);
      drive_w(d, st);
    join
    wait_b(resp);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    drive_ar(a);
    wait_r(d, resp);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 7));
    if (r < 6) return ($urandom % 8) * 4 + ($urandom % 4);
    else if (r == 6) return 32'h40;
    else return $urandom | 32'h100;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    vectors = 0; miscompares = 0;
    iRST = 1;
    bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.bready = 1;
    bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 1;
    ro_data = '0;
    ro_data[95:64] = 32'h0BADF00D;
    repeat (3) @(posedge iCLK);
    #1 iRST = 0;

    // 1: aligned full-word write/read
    do_write(32'h04, 32'hDEADBEEF, 4'hF, resp);
    chk("t1_bresp", resp, 2'b00);
    do_read(32'h04, d, resp);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", resp, 2'b00);
    chk("t1_oregs", oregs[63:32], 32'hDEADBEEF);

    // 2: W leads AW by three cycles, partial strobe
    fork
      drive_w(32'h11223344, 4'h5);
      begin
        repeat (2) @(negedge iCLK);
        chk("t2_wready_held", bus.wready, 1'b0);
        @(posedge iCLK); #1;
        drive_aw(32'h04);
      end
    join
    wait_b(resp);
    chk("t2_bresp", resp, 2'b00);
    chk("t2_oregs", oregs[63:32], 32'hDE22BE44);

    // 3: out-of-range and read-only accesses
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, resp);
    chk("t3_oor_bresp", resp, 2'b10);
    do_read(32'h40, d, resp);
    chk("t3_oor_rdata", d, 0);
    chk("t3_oor_rresp", resp, 2'b10);
    do_write(32'h08, 32'h12121212, 4'hF, resp);
    chk("t3_ro_bresp", resp, 2'b10);
    do_read(32'h0A, d, resp);
    chk("t3_ro_rdata", d, 32'h0BADF00D);
    chk("t3_ro_rresp", resp, 2'b00);
    chk("t3_ro_oregs", oregs[95:64], 0);
    chk("t3_reg1_kept", oregs[63:32], 32'hDE22BE44);

    // 4: B back-pressure with a second write queued behind it
    bus.bready = 0;
    do_write(32'h0C, 32'h12345678, 4'hF, resp);
    fork
      drive_aw(32'h0C);
      drive_w(32'hCAFEF00D, 4'hF);
    join
    repeat (5) begin
      @(negedge iCLK);
      chk("t4_bvalid_hold", bus.bvalid, 1'b1);
      chk("t4_bresp_hold", bus.bresp, 2'b00);
      chk("t4_reg3_old", oregs[127:96], 32'h12345678);
    end
    @(posedge iCLK); #1 bus.bready = 1;
    @(negedge iCLK);
    @(negedge iCLK);
    chk("t4_bvalid_gap", bus.bvalid, 1'b0);
    chk("t4_reg3_gap", oregs[127:96], 32'h12345678);
    @(posedge iCLK); #1;
    wait_b(resp);
    chk("t4_bresp2", resp, 2'b00);
    chk("t4_reg3_new", oregs[127:96], 32'hCAFEF00D);

    // 5: read and commit to the same register on the same edge
    do_write(32'h04, 32'hA5A5A5A5, 4'hF, resp);
    bus.awvalid = 1; bus.awaddr = 32'h04; bus.wvalid = 1; bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF;
    @(posedge iCLK); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    bus.arvalid = 1; bus.araddr = 32'h04;
    @(posedge iCLK); #1;
    bus.arvalid = 0;
    @(negedge iCLK);
    chk("t5_collide_rdata", bus.rdata, 32'hA5A5A5A5);
    chk("t5_collide_bvalid", bus.bvalid, 1'b1);
    @(posedge iCLK); #1;
    do_read(32'h04, d, resp);
    chk("t5_after_rdata", d, 32'h5A5A5A5A);

    // 6: asynchronous reset mid-transaction
    bus.rready = 0;
    drive_ar(32'h0C);
    drive_aw(32'h10);
    @(negedge iCLK);
    chk("t6_rvalid_pre", bus.rvalid, 1'b1);
    chk("t6_awready_pre", bus.awready, 1'b0);
    @(posedge iCLK); #3 iRST = 1;
    #1;
    chk("t6_rvalid_rst", bus.rvalid, 1'b0);
    chk("t6_awready_rst", bus.awready, 1'b0);
    chk("t6_oregs_rst", oregs, '0);
    repeat (2) @(posedge iCLK);
    #1 iRST = 0; bus.rready = 1;
    do_write(32'h14, 32'h600DCAFE, 4'hF, resp);
    chk("t6_bresp", resp, 2'b00);
    do_read(32'h14, d, resp);
    chk("t6_rdata", d, 32'h600DCAFE);
    chk("t6_reg1_cleared", oregs[63:32], 0);

    // randomized traffic, valids held until accepted
    for (int c = 0; c < 600; c++) begin
      bit aw_acc, w_acc, ar_acc;
      @(negedge iCLK);
      aw_acc = bus.awvalid && bus.awready;
      w_acc  = bus.wvalid && bus.wready;
      ar_acc = bus.arvalid && bus.arready;
      @(posedge iCLK); #1;
      if (!bus.awvalid || aw_acc) begin
        bus.awvalid = ($urandom % 3) == 0; bus.awaddr = rand_addr(); bus.awprot = 3'($urandom);
      end
      if (!bus.wvalid || w_acc) begin
        bus.wvalid = ($urandom % 3) == 0; bus.wdata = $urandom; bus.wstrb = 4'($urandom);
      end
      if (!bus.arvalid || ar_acc) begin
        bus.arvalid = ($urandom % 2) == 0; bus.araddr = rand_addr(); bus.arprot = 3'($urandom);
      end
      bus.bready = ($urandom % 4) != 0;
      bus.rready = ($urandom % 4) != 0;
      for (int i = 0; i < 8; i++) ro_data[i*32 +: 32] = $urandom;
    end
    @(negedge iCLK);
    @(posedge iCLK); #1;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    bus.bready = 1; bus.rready = 1;
    repeat (10) @(posedge iCLK);
    @(negedge iCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
